// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the instruction/data memory port arbiter.
//   owner_e       : identifies which pipeline requester issued a transaction
//   SIZE_*        : encodings of the shared-port size field
//   resp_entry_t  : one response-tracking entry {owner, discard}
//   mem_cmd_t     : the full request payload presented on the shared port
//   ptr_width()   : pointer width helper that stays legal for depth 1
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'h0;
  localparam logic [1:0] SIZE_H = 2'h1;
  localparam logic [1:0] SIZE_W = 2'h2;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } resp_entry_t;

  localparam int RESP_ENTRY_W = $bits(resp_entry_t);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // A depth-1 FIFO still needs a 1-bit pointer so the declarations stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_resp_owner_fifo.sv
// ---------------------------------------------------------------------------
// resp_owner_fifo
// Small synchronous FIFO remembering, for each accepted transaction, which
// requester owns it and whether its response must be thrown away.
// Ports:
//   clk, resetn    : clock, synchronous active-low reset (empties the FIFO)
//   push_i         : write push_entry_i (ignored while full)
//   push_entry_i   : {owner, discard} of the transaction just accepted
//   pop_i          : retire the head entry (ignored while empty)
//   full_o/empty_o : occupancy flags
//   head_o         : oldest entry, read combinationally
// ---------------------------------------------------------------------------
module resp_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output resp_entry_t head_o
);

  localparam int PTR_W = ptr_width(OUTSTANDING);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  resp_entry_t      entries_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = entries_q[rd_ptr_q];

  // Entry storage carries no reset: only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // Pointers wrap explicitly so non-power-of-two-safe logic is not assumed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one split-transaction (req/addr_ok/data_ok) memory port between the
// IF-stage fetch and the EX-stage data access. A request that is not accepted
// immediately is locked into a hold register and replayed unchanged until the
// port accepts it. Accepted transactions are tracked in issue order so each
// response is routed back to its issuer, or dropped if the issuer abandoned it.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   inst_req/inst_addr          : fetch request (always a word read)
//   inst_addr_ok/inst_data_ok   : fetch accepted / fetch data returned
//   inst_rdata                  : fetch data (passthrough of mem_rdata)
//   data_req/wr/size/wstrb/addr/wdata : load/store request
//   data_addr_ok/data_data_ok   : data accepted / data response
//   data_rdata                  : load data (passthrough of mem_rdata)
//   mem_req/wr/size/wstrb/addr/wdata  : shared-port request
//   mem_addr_ok/data_ok/rdata   : shared-port accept / response / read data
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  // Lock state: a presented-but-unaccepted request and its frozen payload.
  logic        lock_valid_q, lock_valid_d;
  logic        lock_drop_q,  lock_drop_d;
  owner_e      lock_owner_q, lock_owner_d;
  mem_cmd_t    hold_q,       hold_d;

  owner_e      owner;
  logic        owner_req;
  mem_cmd_t    inst_cmd;
  mem_cmd_t    data_cmd;
  mem_cmd_t    owner_cmd;
  mem_cmd_t    mem_cmd;
  logic        xfer;
  logic        grant_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic        resp_valid;
  resp_entry_t push_entry;
  resp_entry_t head;

  // ---------------- owner selection ----------------
  always_comb begin
    if (lock_valid_q) begin
      owner = lock_owner_q;
    end else if (inst_req && data_req) begin
      owner = DATA_FIRST ? OWNER_DATA : OWNER_INST;
    end else if (data_req) begin
      owner = OWNER_DATA;
    end else begin
      owner = OWNER_INST;
    end
  end

  assign owner_req = (owner == OWNER_DATA) ? data_req : inst_req;

  // ---------------- payload ----------------
  assign inst_cmd = '{wr: 1'b0, size: SIZE_W, wstrb: 4'h0, addr: inst_addr, wdata: 32'h0};
  assign data_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};
  assign owner_cmd = (owner == OWNER_DATA) ? data_cmd : inst_cmd;

  // A locked request is replayed regardless of the requester or FIFO state;
  // the FIFO cannot be full while locked because nothing was pushed since the
  // lock was taken with room available.
  assign mem_req = lock_valid_q | (owner_req & ~fifo_full);
  // Payload is forced to zero when idle so the port is quiet between requests.
  assign mem_cmd = lock_valid_q ? hold_q : (mem_req ? owner_cmd : '0);

  assign mem_wr    = mem_cmd.wr;
  assign mem_size  = mem_cmd.size;
  assign mem_wstrb = mem_cmd.wstrb;
  assign mem_addr  = mem_cmd.addr;
  assign mem_wdata = mem_cmd.wdata;

  // ---------------- handshake ----------------
  assign xfer = mem_req & mem_addr_ok;
  // A requester that abandoned a locked request must not see the acceptance,
  // even if it has already raised a fresh request in the meantime.
  assign grant_ok     = xfer & owner_req & ~(lock_valid_q & lock_drop_q);
  assign inst_addr_ok = grant_ok & (owner == OWNER_INST);
  assign data_addr_ok = grant_ok & (owner == OWNER_DATA);

  // ---------------- lock next state ----------------
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_drop_d  = lock_drop_q;
    lock_owner_d = lock_owner_q;
    hold_d       = hold_q;
    if (lock_valid_q) begin
      if (mem_addr_ok) begin
        lock_valid_d = 1'b0;
        lock_drop_d  = 1'b0;
      end else begin
        lock_drop_d = lock_drop_q | ~owner_req;
      end
    end else if (mem_req && !mem_addr_ok) begin
      lock_valid_d = 1'b1;
      lock_drop_d  = 1'b0;
      lock_owner_d = owner;
      hold_d       = owner_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_drop_q  <= 1'b0;
      lock_owner_q <= OWNER_INST;
      hold_q       <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_drop_q  <= lock_drop_d;
      lock_owner_q <= lock_owner_d;
      hold_q       <= hold_d;
    end
  end

  // ---------------- response tracking ----------------
  // The drop flag only updates on the next edge, so a request withdrawn in the
  // accepting cycle itself is caught through ~owner_req.
  assign push_entry = '{owner: owner, discard: lock_drop_q | ~owner_req};

  resp_owner_fifo #(
    .OUTSTANDING (OUTSTANDING)
  ) u_resp_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (xfer),
    .push_entry_i (push_entry),
    .pop_i        (mem_data_ok),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head)
  );

  assign resp_valid   = mem_data_ok & ~fifo_empty & ~head.discard;
  assign inst_data_ok = resp_valid & (head.owner == OWNER_INST);
  assign data_data_ok = resp_valid & (head.owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // A response with nothing outstanding is a protocol violation downstream.
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mem_data_ok && fifo_empty))
        else $error("mem_port_arbiter: mem_data_ok with no outstanding transaction");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.OUTSTANDING(2), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  initial begin
    resetn = 0;
    idle();
    tick(); tick();
    resetn = 1;

    // ---------------- reset state ----------------
    settle();
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.inst_addr_ok", inst_addr_ok, 0);
    chk("rst.data_addr_ok", data_addr_ok, 0);
    chk("rst.inst_data_ok", inst_data_ok, 0);
    chk("rst.data_data_ok", data_data_ok, 0);
    tick();

    // ---------------- same-cycle conflict ----------------
    inst_req = 1; inst_addr = 32'h1c00_0000;
    data_req = 1; data_addr = 32'h8000_0010; data_size = 2'h2; mem_addr_ok = 1;
    settle();
    $display("[TB] conflict: data granted first");
    chk("conf.mem_req", mem_req, 1);
    chk("conf.mem_addr_data", mem_addr, 32'h8000_0010);
    chk("conf.data_addr_ok", data_addr_ok, 1);
    chk("conf.inst_addr_ok0", inst_addr_ok, 0);
    tick();
    data_req = 0;
    settle();
    $display("[TB] conflict: inst granted next");
    chk("conf.mem_addr_inst", mem_addr, 32'h1c00_0000);
    chk("conf.inst_addr_ok", inst_addr_ok, 1);
    chk("conf.inst_size", mem_size, 2'h2);
    chk("conf.inst_wr", mem_wr, 0);
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1111_2222;
    settle();
    $display("[TB] conflict: first response");
    chk("conf.resp1_data_ok", data_data_ok, 1);
    chk("conf.resp1_inst_ok", inst_data_ok, 0);
    chk("conf.resp1_rdata", data_rdata, 32'h1111_2222);
    tick();
    mem_rdata = 32'h3333_4444;
    settle();
    $display("[TB] conflict: second response");
    chk("conf.resp2_inst_ok", inst_data_ok, 1);
    chk("conf.resp2_data_ok", data_data_ok, 0);
    chk("conf.resp2_rdata", inst_rdata, 32'h3333_4444);
    tick();
    idle();

    // ---------------- backpressure ----------------
    data_req = 1; data_wr = 1; data_size = 2'h1; data_wstrb = 4'b0011;
    data_addr = 32'h8000_0002; data_wdata = 32'hAABB_CCDD;
    inst_req = 1; inst_addr = 32'h1c00_0080;
    for (int c = 0; c < 3; c++) begin
      settle();
      $display("[TB] backpressure stall cycle %0d", c);
      chk("bp.mem_req", mem_req, 1);
      chk("bp.mem_addr", mem_addr, 32'h8000_0002);
      chk("bp.mem_wstrb", mem_wstrb, 4'b0011);
      chk("bp.mem_wdata", mem_wdata, 32'hAABB_CCDD);
      chk("bp.mem_wr", mem_wr, 1);
      chk("bp.data_addr_ok", data_addr_ok, 0);
      chk("bp.inst_addr_ok", inst_addr_ok, 0);
      tick();
      inst_addr = inst_addr + 4;
    end
    mem_addr_ok = 1;
    settle();
    $display("[TB] backpressure accept");
    chk("bp.acc_data_addr_ok", data_addr_ok, 1);
    chk("bp.acc_inst_addr_ok", inst_addr_ok, 0);
    chk("bp.acc_mem_addr", mem_addr, 32'h8000_0002);
    chk("bp.acc_mem_size", mem_size, 2'h1);
    tick();
    data_req = 0;
    settle();
    $display("[TB] backpressure: inst unblocked");
    chk("bp.inst_go", inst_addr_ok, 1);
    chk("bp.inst_go_addr", mem_addr, inst_addr);
    tick();
    idle();
    mem_data_ok = 1; mem_rdata = 32'h0;
    settle();
    chk("bp.store_done", data_data_ok, 1);
    tick();
    mem_rdata = 32'h5555_6666;
    settle();
    chk("bp.fetch_done", inst_data_ok, 1);
    tick();
    idle();

    // ---------------- dropped request ----------------
    data_req = 1; data_addr = 32'h8000_0100; data_size = 2'h2;
    settle();
    $display("[TB] drop: lock data load");
    chk("drop.mem_req", mem_req, 1);
    chk("drop.data_addr_ok0", data_addr_ok, 0);
    tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h1c00_0040;
    settle();
    chk("drop.hold_addr", mem_addr, 32'h8000_0100);
    chk("drop.inst_blocked", inst_addr_ok, 0);
    tick();
    mem_addr_ok = 1;
    settle();
    $display("[TB] drop: downstream accepts dropped load");
    chk("drop.acc_addr", mem_addr, 32'h8000_0100);
    chk("drop.no_data_addr_ok", data_addr_ok, 0);
    chk("drop.no_inst_addr_ok", inst_addr_ok, 0);
    tick();
    settle();
    $display("[TB] drop: next fetch");
    chk("drop.fetch_addr", mem_addr, 32'h1c00_0040);
    chk("drop.fetch_ok", inst_addr_ok, 1);
    tick();
    idle();
    mem_data_ok = 1; mem_rdata = 32'h7777_8888;
    settle();
    chk("drop.discard_data_ok", data_data_ok, 0);
    chk("drop.discard_inst_ok", inst_data_ok, 0);
    tick();
    mem_rdata = 32'h9999_AAAA;
    settle();
    chk("drop.fetch_resp", inst_data_ok, 1);
    chk("drop.fetch_resp_d", data_data_ok, 0);
    tick();
    idle();

    // ---------------- outstanding limit ----------------
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < 2; k++) begin
      inst_addr = 32'h1c00_0100 + 32'(k * 4);
      settle();
      $display("[TB] limit: fetch %0d", k);
      chk("lim.fetch_ok", inst_addr_ok, 1);
      tick();
    end
    inst_addr = 32'h1c00_0108;
    settle();
    $display("[TB] limit: third fetch blocked");
    chk("lim.third_mem_req", mem_req, 0);
    chk("lim.third_addr_ok", inst_addr_ok, 0);
    tick();
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    $display("[TB] limit: pop while full");
    chk("lim.pop_mem_req", mem_req, 0);
    chk("lim.pop_data_ok", inst_data_ok, 1);
    chk("lim.pop_rdata", inst_rdata, 32'hDEAD_BEEF);
    tick();
    mem_data_ok = 0;
    settle();
    $display("[TB] limit: issue resumes");
    chk("lim.resume_req", mem_req, 1);
    chk("lim.resume_ok", inst_addr_ok, 1);
    chk("lim.resume_addr", mem_addr, 32'h1c00_0108);
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      mem_data_ok = 1; mem_rdata = 32'h0000_1000 + 32'(k);
      settle();
      chk("lim.drain", inst_data_ok, 1);
      tick();
    end
    idle();

    // ---------------- reset mid-transaction ----------------
    data_req = 1; data_addr = 32'h8000_0200; data_size = 2'h2; mem_addr_ok = 1;
    settle();
    chk("rmid.first_ok", data_addr_ok, 1);
    tick();
    data_addr = 32'h8000_0204; mem_addr_ok = 0;
    settle();
    chk("rmid.lock_ok0", data_addr_ok, 0);
    tick();
    settle();
    chk("rmid.locked_addr", mem_addr, 32'h8000_0204);
    tick();
    resetn = 0; idle();
    tick();
    resetn = 1;
    settle();
    $display("[TB] reset mid-transaction: state cleared");
    chk("rmid.mem_req", mem_req, 0);
    chk("rmid.inst_addr_ok", inst_addr_ok, 0);
    chk("rmid.data_addr_ok", data_addr_ok, 0);
    chk("rmid.inst_data_ok", inst_data_ok, 0);
    chk("rmid.data_data_ok", data_data_ok, 0);
    tick();
    // An empty FIFO accepts exactly two fetches before blocking.
    inst_req = 1; inst_addr = 32'h1c00_0200; mem_addr_ok = 1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("rmid.refill_ok", inst_addr_ok, 1);
      tick();
    end
    settle();
    chk("rmid.refill_full", mem_req, 0);
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      mem_data_ok = 1;
      settle();
      chk("rmid.drain", inst_data_ok, 1);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
